// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between fetch, the immediate generator and the register-read stage.
// master drives instructions, flush and out_ready; slave is the immediate generator.
interface imm_gen_pipe_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport master (
        output flush, in_valid, inst, pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );

    modport slave (
        input  flush, in_valid, inst, pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with pc+imm target and a small output FIFO.
// Define IMM_GEN_ILLEGAL_DET_EN to flag unknown opcodes through out_illegal.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    imm_gen_pipe_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        FMT_R     = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_SHAMT = 3'd6
    } fmt_e;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_OP_IMM32 = 7'b0011011,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_OP_32    = 7'b0111011,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        fmt_e            fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } entry_t;

    logic [31:0]     inst;
    logic [31:0]     imm32;
    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    logic            shamt_hi;
    entry_t          dec_entry;

    assign inst     = bus.inst;
    // RV64 shifts use a 6-bit shamt; on RV32 inst[25] is a funct7 bit and must not leak.
    assign shamt_hi = (XLEN == 64) ? inst[25] : 1'b0;

    // NOTE: every output of this always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        imm32       = '0;
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
        case (inst[6:0])
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                imm32   = {{20{inst[31]}}, inst[31:20]};
                dec_fmt = FMT_I;
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                if (inst[13:12] == 2'b01) begin
                    imm32   = {26'd0, shamt_hi, inst[24:20]};
                    dec_fmt = FMT_SHAMT;
                end else begin
                    imm32   = {{20{inst[31]}}, inst[31:20]};
                    dec_fmt = FMT_I;
                end
            end
            OPC_STORE: begin
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                dec_fmt = FMT_S;
            end
            OPC_BRANCH: begin
                imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                dec_fmt = FMT_B;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm32   = {inst[31:12], 12'd0};
                dec_fmt = FMT_U;
            end
            OPC_JAL: begin
                imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                dec_fmt = FMT_J;
            end
            OPC_OP, OPC_OP_32, OPC_MISC_MEM: begin
                dec_fmt = FMT_R;
            end
            default: begin
`ifdef IMM_GEN_ILLEGAL_DET_EN
                dec_illegal = 1'b1;
`else
                dec_illegal = 1'b0;
`endif
            end
        endcase
    end

    assign dec_imm   = XLEN'(signed'(imm32));
    assign dec_entry = '{imm: dec_imm, fmt: dec_fmt, target: bus.pc + dec_imm,
                         illegal: dec_illegal};

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            in_ready;
    logic            push;
    logic            pop;

    assign push       = bus.in_valid & in_ready;
    assign pop        = bus.out_valid & bus.out_ready;
    assign count_next = count + CW'(push) - CW'(pop);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b1;
            // NOTE: the storage is reset only because the outputs must read zero after reset;
            // a deeper FIFO would leave the array unreset and gate the outputs instead.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= dec_entry;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count    <= count_next;
            in_ready <= (count_next < CW'(DEPTH));
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (count != '0);
    assign bus.out_imm     = mem[rd_ptr].imm;
    assign bus.out_fmt     = mem[rd_ptr].fmt;
    assign bus.out_target  = mem[rd_ptr].target;
    assign bus.out_illegal = mem[rd_ptr].illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe (XLEN=32, DEPTH=2): decode vector table plus
// hand-written backpressure, streaming, flush and reset sequences.
module tb_imm_gen_pipe;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

`ifdef IMM_GEN_ILLEGAL_DET_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    imm_gen_pipe_if #(.XLEN(32)) bus ();

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
        logic        ill;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_head(input string name, input logic [31:0] imm, input logic [2:0] fmt,
                              input logic [31:0] tgt, input logic ill);
        check({name, ".valid"},   64'(bus.out_valid),   64'(1'b1));
        check({name, ".imm"},     64'(bus.out_imm),     64'(imm));
        check({name, ".fmt"},     64'(bus.out_fmt),     64'(fmt));
        check({name, ".target"},  64'(bus.out_target),  64'(tgt));
        check({name, ".illegal"}, 64'(bus.out_illegal), 64'(ill));
    endtask

    task automatic drive(input logic valid, input logic [31:0] inst, input logic [31:0] pc);
        bus.in_valid = valid;
        bus.inst     = inst;
        bus.pc       = pc;
    endtask

    initial begin
        errors = 0;
        checks = 0;

        vecs[0]  = '{"addi_neg1",   32'hFFF00093, 32'h0000_0100, 32'hFFFF_FFFF, 3'd1, 32'h0000_00FF, 1'b0};
        vecs[1]  = '{"beq_m4",      32'hFE000EE3, 32'h0000_0200, 32'hFFFF_FFFC, 3'd3, 32'h0000_01FC, 1'b0};
        vecs[2]  = '{"lui",         32'h123450B7, 32'h0000_0300, 32'h1234_5000, 3'd4, 32'h1234_5300, 1'b0};
        vecs[3]  = '{"srai_1",      32'h4010D093, 32'h0000_0400, 32'h0000_0001, 3'd6, 32'h0000_0401, 1'b0};
        vecs[4]  = '{"sw_m4",       32'hFE112E23, 32'h0000_1000, 32'hFFFF_FFFC, 3'd2, 32'h0000_0FFC, 1'b0};
        vecs[5]  = '{"jal_p8",      32'h008000EF, 32'h0000_2000, 32'h0000_0008, 3'd5, 32'h0000_2008, 1'b0};
        vecs[6]  = '{"jal_m4",      32'hFFDFF0EF, 32'h0000_0010, 32'hFFFF_FFFC, 3'd5, 32'h0000_000C, 1'b0};
        vecs[7]  = '{"auipc_hi",    32'h80000297, 32'h1000_0000, 32'h8000_0000, 3'd4, 32'h9000_0000, 1'b0};
        vecs[8]  = '{"add_r",       32'h002081B3, 32'h0000_0050, 32'h0000_0000, 3'd0, 32'h0000_0050, 1'b0};
        vecs[9]  = '{"lw_7ff",      32'h7FF12083, 32'hFFFF_F000, 32'h0000_07FF, 3'd1, 32'hFFFF_F7FF, 1'b0};
        vecs[10] = '{"jalr_0",      32'h00008067, 32'h0000_0040, 32'h0000_0000, 3'd1, 32'h0000_0040, 1'b0};
        vecs[11] = '{"slli_31",     32'h01F09093, 32'h0000_0000, 32'h0000_001F, 3'd6, 32'h0000_001F, 1'b0};
        vecs[12] = '{"srai_bit25",  32'h43F0D093, 32'h0000_0100, 32'h0000_001F, 3'd6, 32'h0000_011F, 1'b0};
        vecs[13] = '{"illegal_7f",  32'h0000007F, 32'h0000_0060, 32'h0000_0000, 3'd0, 32'h0000_0060, ILL_EN};
        vecs[14] = '{"illegal_lo",  32'h00000010, 32'h0000_0070, 32'h0000_0000, 3'd0, 32'h0000_0070, ILL_EN};
        vecs[15] = '{"addi_wrap",   32'h02000093, 32'hFFFF_FFF0, 32'h0000_0020, 3'd1, 32'h0000_0010, 1'b0};

        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        sample();
        check("reset.out_valid",   64'(bus.out_valid),   64'(0));
        check("reset.in_ready",    64'(bus.in_ready),    64'(1));
        check("reset.out_imm",     64'(bus.out_imm),     64'(0));
        check("reset.out_fmt",     64'(bus.out_fmt),     64'(0));
        check("reset.out_target",  64'(bus.out_target),  64'(0));
        check("reset.out_illegal", 64'(bus.out_illegal), 64'(0));
        tick();

        // Decode table: one push, head appears next cycle, pop leaves the FIFO empty.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, vecs[i].inst, vecs[i].pc);
            bus.out_ready = 1'b1;
            tick();
            drive(1'b0, 32'h0, 32'h0);
            sample();
            check_head(vecs[i].name, vecs[i].imm, vecs[i].fmt, vecs[i].tgt, vecs[i].ill);
            tick();
            sample();
            check({vecs[i].name, ".empty_after_pop"}, 64'(bus.out_valid), 64'(0));
            tick();
        end

        // Backpressure: third push refused while full, first two drain in order.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h100);
        tick();
        drive(1'b1, 32'h123450B7, 32'h300);
        tick();
        drive(1'b1, 32'h008000EF, 32'h2000);
        sample();
        check("full.in_ready", 64'(bus.in_ready), 64'(0));
        check_head("full.head_a", 32'hFFFF_FFFF, 3'd1, 32'h0000_00FF, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;
        sample();
        check("full.still_full", 64'(bus.in_ready), 64'(0));
        tick();
        sample();
        check_head("drain.head_b", 32'h1234_5000, 3'd4, 32'h1234_5300, 1'b0);
        check("drain.in_ready", 64'(bus.in_ready), 64'(1));
        tick();
        sample();
        check("drain.no_third", 64'(bus.out_valid), 64'(0));
        tick();

        // Full with concurrent pop: held push accepted only one cycle later.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00008067, 32'h40);
        tick();
        drive(1'b1, 32'hFE112E23, 32'h1000);
        tick();
        drive(1'b1, 32'h4010D093, 32'h400);
        bus.out_ready = 1'b1;
        sample();
        check("fullpop.in_ready_before", 64'(bus.in_ready), 64'(0));
        tick();
        sample();
        check_head("fullpop.head_s", 32'hFFFF_FFFC, 3'd2, 32'h0000_0FFC, 1'b0);
        check("fullpop.in_ready_after", 64'(bus.in_ready), 64'(1));
        tick();
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check_head("fullpop.head_c", 32'h0000_0001, 3'd6, 32'h0000_0401, 1'b0);
        tick();
        sample();
        check("fullpop.empty", 64'(bus.out_valid), 64'(0));
        tick();

        // Streaming push+pop every cycle at count=1, exercising pointer wrap.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vecs[i].inst, vecs[i].pc);
            if (i > 0) begin
                sample();
                check_head({"stream.", vecs[i-1].name}, vecs[i-1].imm, vecs[i-1].fmt,
                           vecs[i-1].tgt, vecs[i-1].ill);
                check("stream.in_ready", 64'(bus.in_ready), 64'(1));
            end
            tick();
        end
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check_head("stream.last", vecs[4].imm, vecs[4].fmt, vecs[4].tgt, vecs[4].ill);
        tick();
        sample();
        check("stream.empty", 64'(bus.out_valid), 64'(0));
        tick();

        // Flush with two buffered entries and a concurrent push: all lost.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h100);
        tick();
        drive(1'b1, 32'hFE000EE3, 32'h200);
        tick();
        drive(1'b1, 32'h123450B7, 32'h300);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check("flush.out_valid", 64'(bus.out_valid), 64'(0));
        check("flush.in_ready",  64'(bus.in_ready),  64'(1));
        tick();
        sample();
        check("flush.concurrent_lost", 64'(bus.out_valid), 64'(0));
        drive(1'b1, 32'h008000EF, 32'h2000);
        bus.out_ready = 1'b1;
        tick();
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check_head("flush.after", 32'h0000_0008, 3'd5, 32'h0000_2008, 1'b0);
        tick();

        // Mid-stream reset beats a concurrent flush and push; outputs return to zero.
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 32'h100);
        tick();
        drive(1'b1, 32'hFE000EE3, 32'h200);
        tick();
        drive(1'b1, 32'h123450B7, 32'h300);
        reset     = 1'b1;
        bus.flush = 1'b1;
        tick();
        reset     = 1'b0;
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        sample();
        check("rst2.out_valid",  64'(bus.out_valid),  64'(0));
        check("rst2.in_ready",   64'(bus.in_ready),   64'(1));
        check("rst2.out_imm",    64'(bus.out_imm),    64'(0));
        check("rst2.out_fmt",    64'(bus.out_fmt),    64'(0));
        check("rst2.out_target", 64'(bus.out_target), 64'(0));
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
